dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, meaning byte-address width; depth is 2^(ADDR_W-2) 32-bit words.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width; only 32 is supported.
REQ-003 SHALL have parameter RD_LAT, default 2, range 1..7, meaning cycles from request accept to response valid.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, responder can accept a request.
REQ-008 SHALL have port req_we, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, ADDR_W, byte address; bits [1:0] are ignored for indexing.
REQ-010 SHALL have port req_wdata, input, DATA_W, write data, already lane-aligned.
REQ-011 SHALL have port req_be, input, 4, byte lane enables; bit i covers bits [8i+7:8i].
REQ-012 SHALL have port rsp_valid, output, 1, response present.
REQ-013 SHALL have port rsp_ready, input, 1, initiator accepts response.
REQ-014 SHALL have port rsp_rdata, output, DATA_W, full read word; 0 for writes.
REQ-015 SHALL have port rsp_err, output, 1, access fault flag.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; at most one request outstanding.
REQ-017 SHALL assert req_ready only in IDLE; accept on req_valid & req_ready.
REQ-018 SHALL on accept latch we, word index, wdata, be; load latency counter with RD_LAT-1.
REQ-019 SHALL for RD_LAT=1 go IDLE -> RESP directly; otherwise stay in WAIT, decrementing each cycle, until counter = 0.
REQ-020 SHALL perform write in the accept cycle, updating only enabled lanes; other lanes unchanged.
REQ-021 SHALL capture read data into rsp_rdata on the WAIT->RESP (or IDLE->RESP) transition; rsp_rdata stable throughout RESP.
REQ-022 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready = 1; then return to IDLE next cycle.
REQ-023 SHALL not accept a new request in the cycle the response handshake completes (req_ready rises the following cycle).
REQ-024 SHALL treat req_be = 0000 on a write as no-op with normal response.
REQ-025 SHALL ignore req_* inputs in WAIT and RESP.
REQ-026 SHALL treat req_addr wrap-around beyond depth as impossible (index is exactly ADDR_W-2 bits).

Reset
REQ-027 SHALL on reset force state IDLE, counter 0, req_ready 0 during reset then 1 the cycle after, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-028 SHALL on reset mid-transaction abandon the response; a write already performed in the accept cycle remains.
REQ-029 SHALL not initialise memory contents on reset.

Configuration
REQ-030 SHALL, with DMEM_ALIGN_CHECK_EN defined, flag rsp_err = 1 when req_be is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111; the faulting write is suppressed and rsp_rdata = 0; latency unchanged.
REQ-031 SHALL, without DMEM_ALIGN_CHECK_EN, accept any req_be pattern and tie rsp_err to 0.

Verification
REQ-032 SHALL verify write word 0x12345678 at addr 0x010 be 1111, then read 0x010 with RD_LAT=2 -> rsp_valid 2 cycles after accept, rsp_rdata 0x12345678, rsp_err 0.
REQ-033 SHALL verify byte write 0xAB000000 be 1000 to addr 0x013 over 0x12345678, then read -> 0xAB345678.
REQ-034 SHALL verify rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready 0, second req_valid ignored.
REQ-035 SHALL verify reset asserted during WAIT -> next cycle rsp_valid 0, state IDLE, req_ready 1 one cycle after reset deasserts.
REQ-036 SHALL verify with DMEM_ALIGN_CHECK_EN write be 0101 data 0xFFFFFFFF to 0x020 holding 0 -> rsp_err 1, later read returns 0x00000000; without macro -> rsp_err 0, read returns 0x00FF00FF.
REQ-037 SHALL verify RD_LAT=1 back-to-back reads -> each rsp_valid 1 cycle after accept, one idle cycle between handshakes.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bus between a data-memory initiator and dmem_responder.
// master = initiator side, slave = responder side.
interface dmem_responder_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed read latency RD_LAT.
// Optional macro DMEM_ALIGN_CHECK_EN flags illegal byte-enable patterns as faults.
module dmem_responder #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);
  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               we_q;
  logic [IDX_W-1:0]   idx_q;
  logic               err_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic               rsp_err_q;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               accept;
  logic               capture;
  logic               be_bad;
  logic               cap_we;
  logic               cap_err;
  logic [IDX_W-1:0]   req_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               unused_addr_lsb;

  assign req_idx         = bus.req_addr[ADDR_W-1:2];
  assign unused_addr_lsb = &{1'b0, bus.req_addr[1:0]};
  assign bus.req_ready   = (state_q == IDLE) && !reset;
  assign accept          = bus.req_valid && bus.req_ready;

`ifdef DMEM_ALIGN_CHECK_EN
  // Only naturally aligned byte, halfword and word lane groups are legal.
  always_comb begin
    be_bad = 1'b1;
    case (bus.req_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_bad = 1'b0;
      default:                   be_bad = 1'b1;
    endcase
  end
`else
  assign be_bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = 3'(RD_LAT - 1);
          if (RD_LAT == 1) begin
            state_d = RESP;
            capture = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = RESP;
          capture = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With RD_LAT=1 the capture happens in the accept cycle, so take the live request.
  assign cap_we  = (state_q == IDLE) ? bus.req_we : we_q;
  assign cap_err = (state_q == IDLE) ? be_bad     : err_q;
  assign rd_idx  = (state_q == IDLE) ? req_idx    : idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q  <= bus.req_we;
        idx_q <= req_idx;
        err_q <= be_bad;
      end
      if (capture) begin
        rsp_rdata_q <= (cap_we || cap_err) ? '0 : mem[rd_idx];
        rsp_err_q   <= cap_err;
      end
    end
  end

  // Memory is never reset; writes land in the accept cycle, faulting writes are dropped.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !be_bad) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req_be[i]) mem[req_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench: RD_LAT=2 responder (main) and RD_LAT=1 responder
// (back-to-back stream), both checked against a word-array memory model.
module tb_dmem_responder;
  localparam int AW    = 9;
  localparam int WORDS = 128;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W(AW), .DATA_W(32)) ifa ();
  dmem_responder_if #(.ADDR_W(AW), .DATA_W(32)) ifb ();

  dmem_responder #(.ADDR_W(AW), .DATA_W(32), .RD_LAT(2)) u_dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave)
  );
  dmem_responder #(.ADDR_W(AW), .DATA_W(32), .RD_LAT(1)) u_dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave)
  );

  int          err_cnt = 0;
  int          chk_cnt = 0;
  logic [31:0] ma [WORDS];
  logic [31:0] mb [8];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit be_legal(input logic [3:0] be);
    return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // One full transaction on the RD_LAT=2 responder; hold = cycles rsp_ready stays low in RESP.
  task automatic txn_a(input bit we, input logic [8:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input int hold, input string tag);
    logic [31:0] exp_d;
    bit          exp_e;
    int          t;
    int          lat;
    int          idx;
    idx   = int'(addr[8:2]);
    exp_e = CHK_EN && !be_legal(be);
    exp_d = (we || exp_e) ? 32'h0 : ma[idx];
    if (we && !exp_e) ma[idx] = merge(ma[idx], wd, be);

    ifa.req_we = we; ifa.req_addr = addr; ifa.req_wdata = wd; ifa.req_be = be;
    ifa.req_valid = 1'b1; ifa.rsp_ready = 1'b0;
    t = 0;
    while (!ifa.req_ready && t < 20) begin tick(); t++; end
    if (!ifa.req_ready) check_val({tag, " accept_timeout"}, 32'(ifa.req_ready), 32'd1);

    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) begin
        if (hold > 0) begin
          // A competing request that the busy responder must ignore.
          ifa.req_we = 1'b1; ifa.req_addr = addr ^ 9'h004;
          ifa.req_wdata = 32'hDEADBEEF; ifa.req_be = 4'hF;
        end else begin
          ifa.req_valid = 1'b0;
        end
      end
    end while (!ifa.rsp_valid && lat < 20);
    check_val({tag, " latency"}, 32'(lat), 32'd2);

    for (int h = 0; h < hold; h++) begin
      check_val({tag, " hold_valid"}, 32'(ifa.rsp_valid), 32'd1);
      check_val({tag, " hold_rdata"}, ifa.rsp_rdata, exp_d);
      check_val({tag, " hold_req_ready"}, 32'(ifa.req_ready), 32'd0);
      tick();
    end
    check_val({tag, " rdata"}, ifa.rsp_rdata, exp_d);
    check_val({tag, " err"}, 32'(ifa.rsp_err), 32'(exp_e));
    ifa.req_valid = 1'b0;
    ifa.rsp_ready = 1'b1;
    check_val({tag, " hs_req_ready"}, 32'(ifa.req_ready), 32'd0);
    tick();
    ifa.rsp_ready = 1'b0;
    check_val({tag, " post_valid"}, 32'(ifa.rsp_valid), 32'd0);
    check_val({tag, " post_req_ready"}, 32'(ifa.req_ready), 32'd1);
  endtask

  // Accept a request, then reset while the responder is still waiting.
  task automatic abort_a(input bit we, input logic [8:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
    int t;
    if (we && !(CHK_EN && !be_legal(be))) ma[int'(addr[8:2])] = merge(ma[int'(addr[8:2])], wd, be);
    ifa.req_we = we; ifa.req_addr = addr; ifa.req_wdata = wd; ifa.req_be = be;
    ifa.req_valid = 1'b1; ifa.rsp_ready = 1'b1;
    t = 0;
    while (!ifa.req_ready && t < 20) begin tick(); t++; end
    tick();
    ifa.req_valid = 1'b0;
    check_val("abort wait_valid", 32'(ifa.rsp_valid), 32'd0);
    reset = 1'b1;
    tick();
    check_val("abort rst_valid", 32'(ifa.rsp_valid), 32'd0);
    check_val("abort rst_req_ready", 32'(ifa.req_ready), 32'd0);
    reset = 1'b0;
    tick();
    check_val("abort idle_req_ready", 32'(ifa.req_ready), 32'd1);
    check_val("abort idle_valid", 32'(ifa.rsp_valid), 32'd0);
    ifa.rsp_ready = 1'b0;
  endtask

  initial begin
    ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_addr = '0; ifa.req_wdata = '0;
    ifa.req_be = '0; ifa.rsp_ready = 1'b0;
    ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_addr = '0; ifb.req_wdata = '0;
    ifb.req_be = '0; ifb.rsp_ready = 1'b0;

    reset = 1'b1;
    repeat (3) tick();
    check_val("reset req_ready", 32'(ifa.req_ready), 32'd0);
    check_val("reset rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    check_val("reset rsp_rdata", ifa.rsp_rdata, 32'h0);
    check_val("reset rsp_err", 32'(ifa.rsp_err), 32'd0);
    reset = 1'b0;
    tick();
    check_val("reset_release req_ready", 32'(ifa.req_ready), 32'd1);

    for (int i = 0; i < WORDS; i++) txn_a(1'b1, 9'(i << 2), 32'h0, 4'hF, 0, "fill");

    txn_a(1'b1, 9'h010, 32'h12345678, 4'hF, 0, "word_wr");
    txn_a(1'b0, 9'h010, 32'h0,        4'hF, 0, "word_rd");
    txn_a(1'b1, 9'h013, 32'hAB000000, 4'h8, 0, "byte_wr");
    txn_a(1'b0, 9'h010, 32'h0,        4'hF, 0, "byte_rd");
    txn_a(1'b0, 9'h010, 32'h0,        4'hF, 5, "stall_rd");
    txn_a(1'b0, 9'h014, 32'h0,        4'hF, 0, "stall_ignored");
    txn_a(1'b1, 9'h020, 32'h0,        4'hF, 0, "be0101_clr");
    txn_a(1'b1, 9'h020, 32'hFFFFFFFF, 4'h5, 0, "be0101_wr");
    txn_a(1'b0, 9'h020, 32'h0,        4'hF, 0, "be0101_rd");
    txn_a(1'b1, 9'h030, 32'h5A5A5A5A, 4'h0, 0, "be0000_wr");
    txn_a(1'b0, 9'h030, 32'h0,        4'hF, 0, "be0000_rd");

    for (int n = 0; n < 40; n++) begin
      logic [8:0] a;
      a = {3'b000, 4'($urandom_range(0, 15)), 2'($urandom)};
      txn_a(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), "rand");
    end

    abort_a(1'b0, 9'h010, 32'h0, 4'hF);
    abort_a(1'b1, 9'h040, 32'hCAFEF00D, 4'hF);
    txn_a(1'b0, 9'h040, 32'h0, 4'hF, 0, "abort_rd");

    // Back-to-back stream on the RD_LAT=1 responder: 8 writes then 8 reads.
    ifb.req_valid = 1'b1;
    ifb.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] wd;
      logic [31:0] exp_d;
      wd = $urandom;
      ifb.req_we = (i < 8); ifb.req_addr = 9'((i % 8) << 2);
      ifb.req_wdata = wd; ifb.req_be = 4'hF;
      if (i < 8) begin
        mb[i % 8] = wd;
        exp_d = 32'h0;
      end else begin
        exp_d = mb[i % 8];
      end
      check_val("b2b idle_req_ready", 32'(ifb.req_ready), 32'd1);
      tick();
      check_val("b2b valid", 32'(ifb.rsp_valid), 32'd1);
      check_val("b2b rdata", ifb.rsp_rdata, exp_d);
      check_val("b2b resp_req_ready", 32'(ifb.req_ready), 32'd0);
      tick();
      check_val("b2b gap_valid", 32'(ifb.rsp_valid), 32'd0);
    end
    ifb.req_valid = 1'b0;
    ifb.rsp_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule
